// File: rtl/cordic_pkg.sv
// cordic_pkg: shared FSM type and constants for the CORDIC sine/cosine unit.
// Angle and gain constants are Q2.30; users keep the top WIDTH bits.
package cordic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROTATE,
        S_PACK,
        S_DONE
    } state_t;

    // atan(2^-i) in Q2.30, truncated
    localparam logic [31:0] ATAN_TAB [24] = '{
        32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F
    };

    // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)), Q2.30
    localparam logic [31:0] K     = 32'h26DD3B6A;
    // pi/2, Q2.30
    localparam logic [31:0] PI_2  = 32'h6487ED51;

    localparam logic [31:0] NAN_Q = 32'h7FC00000;
    localparam logic [31:0] ONE   = 32'h3F800000;

endpackage

// File: rtl/cordic_sincos_fixed_to_float.sv
// fixed_to_float: signed Q2.(WIDTH-2) fixed point to IEEE-754 single.
// Ports: fixed (WIDTH-bit signed in) -> flt (32-bit float out), RNE rounding.
module fixed_to_float
    import cordic_pkg::*;
#(
    parameter int WIDTH = 28
) (
    input  logic signed [WIDTH-1:0] fixed,
    output logic        [31:0]      flt
);

    logic             sgn;
    logic [WIDTH-1:0] mag;
    int               lead;
    logic [63:0]      ext;
    logic             guard;
    logic             sticky;
    logic             rnd;
    logic [23:0]      mant_r;
    logic [7:0]       expo;

    always_comb begin
        sgn  = fixed[WIDTH-1];
        mag  = sgn ? -fixed : fixed;
        lead = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) lead = i;
        end
        // leading one lands on bit 63; ext[63] doubles as non-zero flag
        ext    = {mag, {(64 - WIDTH){1'b0}}} << (WIDTH - 1 - lead);
        guard  = ext[39];
        sticky = |ext[38:0];
        rnd    = guard & (sticky | ext[40]);
        mant_r = {1'b0, ext[62:40]} + {23'd0, rnd};
        expo   = 8'(lead + 129 - WIDTH) + {7'd0, mant_r[23]};
        if (ext[63])
            flt = {sgn, expo, mant_r[22:0]};
        else
            flt = 32'd0;
    end

endmodule

// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative CORDIC sine/cosine on IEEE-754 single angles.
// Ports: clk, rst, clk_en, start, dataa, n (0=cos,1=sin) -> result, done, err.
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int WIDTH = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic        n,
    output logic [31:0] result,
    output logic        done,
    output logic        err
);

    localparam logic signed [WIDTH-1:0] K_W    = WIDTH'(K >> (32 - WIDTH));
    localparam logic signed [WIDTH-1:0] PI_2_W = WIDTH'(PI_2 >> (32 - WIDTH));
    localparam logic [4:0]              LAST   = 5'(ITER - 1);

    state_t state;
    state_t state_nx;

    logic                    cap_en;
    logic                    load_en;
    logic                    rot_en;
    logic                    pack_en;
    logic                    done_en;

    logic [4:0]              cnt;
    logic [31:0]             din;
    logic                    fn;
    logic                    neg;
    logic                    zero;
    logic                    bad;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
    logic [31:0]             pack_q;

    // float -> fixed conversion of the captured angle magnitude
    logic [7:0]              ld_exp;
    int                      ld_ei;
    int                      ld_rsh;
    logic                    ld_bad;
    logic                    ld_tiny;
    logic                    ld_fold;
    logic signed [WIDTH-1:0] ld_mag;

    always_comb begin
        ld_exp  = din[30:23];
        ld_ei   = {24'd0, ld_exp};
        ld_bad  = ld_exp[7];
        ld_tiny = ld_ei < 129 - WIDTH;
        // value = mant24 * 2^(exp + WIDTH - 152)
        ld_rsh  = 184 - WIDTH - ld_ei;
        ld_mag  = '0;
        if (!ld_bad && !ld_tiny)
            ld_mag = WIDTH'({1'b1, din[22:0], 32'd0} >> ld_rsh);
        ld_fold = ld_mag > PI_2_W;
    end

    // shared shifter / adder operands
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic signed [WIDTH-1:0] at;

    assign xs = x >>> cnt;
    assign ys = y >>> cnt;
    assign at = WIDTH'(ATAN_TAB[cnt] >> (32 - WIDTH));

    // the core works on |angle|; sin picks up the input sign here
    logic signed [WIDTH-1:0] pk_fix;
    logic [31:0]             pk_flt;

    always_comb begin
        pk_fix = fn ? y : x;
        if (fn && neg)
            pk_fix = -pk_fix;
    end

    fixed_to_float #(
        .WIDTH(WIDTH)
    ) u_f2f (
        .fixed(pk_fix),
        .flt  (pk_flt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (clk_en)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_ROTATE;
            S_ROTATE: if (cnt == LAST) state_nx = S_PACK;
            S_PACK:   state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cap_en  = (state == S_IDLE) && start;
        load_en = (state == S_LOAD);
        rot_en  = (state == S_ROTATE);
        pack_en = (state == S_PACK);
        done_en = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            din    <= '0;
            fn     <= 1'b0;
            neg    <= 1'b0;
            zero   <= 1'b0;
            bad    <= 1'b0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            pack_q <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            err  <= 1'b0;
            if (cap_en) begin
                din <= dataa;
                fn  <= n;
            end
            if (load_en) begin
                cnt  <= '0;
                neg  <= din[31];
                bad  <= ld_bad;
                zero <= ld_tiny;
                // beyond pi/2: pre-rotate by +pi/2 (x'=-y0=0, y'=x0=K)
                x    <= ld_fold ? '0 : K_W;
                y    <= ld_fold ? K_W : '0;
                z    <= ld_fold ? ld_mag - PI_2_W : ld_mag;
            end
            if (rot_en) begin
                cnt <= cnt + 5'd1;
                if (z[WIDTH-1]) begin
                    x <= x + ys;
                    y <= y - xs;
                    z <= z + at;
                end else begin
                    x <= x - ys;
                    y <= y + xs;
                    z <= z - at;
                end
            end
            if (pack_en) begin
                if (bad)
                    pack_q <= NAN_Q;
                else if (zero)
                    pack_q <= fn ? 32'd0 : ONE;
                else
                    pack_q <= pk_flt;
            end
            if (done_en) begin
                result <= pack_q;
                done   <= 1'b1;
                err    <= bad;
            end
        end
    end

endmodule

// File: doc/cordic_sincos.md
CORDIC_SINCOS -- requirements
Module: cordic_sincos

Interface
REQ-001 Parameter ITER, default 16: number of CORDIC micro-rotations, legal range 8..24.
REQ-002 Parameter WIDTH, default 28: internal signed fixed-point datapath width, 2 integer bits, legal range ITER+4..32.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clk_en  in  1  global enable; low freezes every register, including the FSM and outputs.
REQ-006 start  in  1  one-cycle request; dataa and n sampled on the same edge.
REQ-007 dataa  in  32  IEEE-754 single angle in radians.
REQ-008 n  in  1  function select: 0 = cos, 1 = sin.
REQ-009 result  out  32  IEEE-754 single result.
REQ-010 done  out  1  one-cycle pulse; result valid in the same cycle.
REQ-011 err  out  1  high with done when the input was NaN, infinity or out of range.

Function
REQ-012 FSM states: IDLE, LOAD, ROTATE, PACK, DONE.
- IDLE -> LOAD on start & clk_en.
- LOAD -> ROTATE after 1 cycle.
- ROTATE -> PACK after ITER cycles.
- PACK -> DONE after 1 cycle.
- DONE -> IDLE after 1 cycle.
REQ-013 Latency: done asserts exactly ITER+3 enabled cycles after the start edge (19 cycles at defaults).
REQ-014 Enabled cycles are counted only while clk_en is high; each low cycle extends the latency by 1, with no state loss.
REQ-015 start outside IDLE is ignored; no queueing.
REQ-016 LOAD: convert the float to fixed point. Legal domain is |angle| < 2.0 (exponent <= 127).
REQ-017 Exponent < 127-WIDTH+2 is treated as 0; denormals are treated as 0.
REQ-018 Exponent > 127, infinity or NaN: result = 0x7FC00000, err = 1, same latency.
REQ-019 ROTATE, rotation mode: x0 = K (gain-compensated constant), y0 = 0, z0 = angle.
- Iteration i uses an arithmetic shift by i and atan(2^-i) from the table.
- Direction is taken from the sign of z.
REQ-020 Pre-quadrant fold for |angle| > pi/2: rotate by ±pi/2 first (x' = ∓y, y' = ±x, z ∓ pi/2), then ITER iterations. Latency is unchanged.
REQ-021 PACK: select x (cos) or y (sin), take the sign-magnitude, normalise with a leading-one search, round to nearest-even into a 23-bit mantissa.
REQ-022 A zero magnitude packs to 0x00000000.
REQ-023 Zero input gives exactly 0x3F800000 for cos and exactly 0x00000000 for sin.
REQ-024 Accuracy: |result - true| <= 2^-(ITER-2) over the legal domain.
REQ-025 Sign rules: sin(-a) = -sin(a) bit-exactly; cos(-a) = cos(a) bit-exactly.
REQ-026 result holds its last value until the next done; done is never high for two consecutive enabled cycles.

Reset
REQ-027 On rst high at a clock edge: FSM -> IDLE, result = 0x00000000, done = 0, err = 0, iteration counter = 0.
REQ-028 rst overrides clk_en.
REQ-029 rst mid-operation aborts it; no done is produced for the aborted request.
REQ-030 start on the first edge after rst deasserts is accepted.

Structure
REQ-031 Package cordic_pkg holds:
- the FSM state enum;
- the atan table (24 entries, 32-bit, truncated to WIDTH);
- the K constant;
- the PI_2 constant;
- the float constants NAN_Q = 0x7FC00000 and ONE = 0x3F800000.
REQ-032 One sub-module, fixed_to_float: combinational WIDTH-bit signed fixed-point to IEEE single, with normalisation and rounding; instantiated once in PACK.
REQ-033 The rotation is iterative, with one shared adder set; no unrolled pipeline.

Verification
REQ-034 dataa = 0x3F7CAC08 (0.987), n = 0 -> done at cycle 19, result ≈ 0.5512 ± 6.1e-5, err = 0.
REQ-035 dataa = 0x3F0B851F (0.545), n = 0 -> 0.85513; n = 1 -> 0.51843, each ± 6.1e-5.
REQ-036 dataa = 0xBD8F5C29 (-0.07), n = 1 -> -0.069943; dataa = 0x00000000 -> cos exactly 0x3F800000, sin exactly 0x00000000.
REQ-037 dataa = 0x40400000 (3.0) or 0x7F800000 -> result 0x7FC00000, err = 1, latency 19.
REQ-038 clk_en low for 5 cycles mid-ROTATE -> done at cycle 24 with a result identical to the uninterrupted run; a start pulse while busy is ignored.
REQ-039 rst pulsed during ROTATE -> no done, outputs cleared; the next start completes normally.
